ps2_key_decoder: RTL and testbench

Consumes the byte stream produced by the PS/2 frame receiver and turns it into key events. It resolves the 0xE0 (extended) and 0xF0 (break) prefixes, tracks shift state, suppresses typematic repeats, and maps make codes to ASCII. Events are buffered in a small FIFO and leave through a valid/ready port toward the display/console logic. It also keeps a running count of key presses.

---
 rtl/ps2_pkg.sv | 23 ++
 rtl/ps2_ascii_map.sv | 48 ++++
 rtl/ps2_key_decoder.sv | 149 ++++++++++++++
 tb/tb_ps2_key_decoder.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants, FSM states and event type for the PS/2 key decoder
package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_RSHIFT = 8'h59;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_t;

  typedef struct packed {
    logic       brk;
    logic       ext;
    logic [7:0] code;
    logic [7:0] ascii;
  } ps2_event_t;

endpackage

// File: rtl/ps2_ascii_map.sv
// rtl/ps2_ascii_map.sv - set-2 scan code to ASCII lookup
module ps2_ascii_map (
  input  logic [7:0] code,
  input  logic       ext,
  input  logic       shift,
  output logic [7:0] ascii
);

  logic [7:0] lower;
  logic       is_letter;

  // Lowercase letters first, then shift folds them to uppercase; digits and controls ignore shift
  always_comb begin
    lower     = 8'h00;
    is_letter = 1'b1;
    case (code)
      8'h1C: lower = 8'h61; 8'h32: lower = 8'h62; 8'h21: lower = 8'h63;
      8'h23: lower = 8'h64; 8'h24: lower = 8'h65; 8'h2B: lower = 8'h66;
      8'h34: lower = 8'h67; 8'h33: lower = 8'h68; 8'h43: lower = 8'h69;
      8'h3B: lower = 8'h6A; 8'h42: lower = 8'h6B; 8'h4B: lower = 8'h6C;
      8'h3A: lower = 8'h6D; 8'h31: lower = 8'h6E; 8'h44: lower = 8'h6F;
      8'h4D: lower = 8'h70; 8'h15: lower = 8'h71; 8'h2D: lower = 8'h72;
      8'h1B: lower = 8'h73; 8'h2C: lower = 8'h74; 8'h3C: lower = 8'h75;
      8'h2A: lower = 8'h76; 8'h1D: lower = 8'h77; 8'h22: lower = 8'h78;
      8'h35: lower = 8'h79; 8'h1A: lower = 8'h7A;
      default: is_letter = 1'b0;
    endcase

    ascii = 8'h00;
    if (!ext) begin
      if (is_letter) begin
        ascii = shift ? (lower - 8'h20) : lower;
      end else begin
        case (code)
          8'h45: ascii = 8'h30; 8'h16: ascii = 8'h31; 8'h1E: ascii = 8'h32;
          8'h26: ascii = 8'h33; 8'h25: ascii = 8'h34; 8'h2E: ascii = 8'h35;
          8'h36: ascii = 8'h36; 8'h3D: ascii = 8'h37; 8'h3E: ascii = 8'h38;
          8'h46: ascii = 8'h39;
          8'h29: ascii = 8'h20;
          8'h5A: ascii = 8'h0D;
          8'h66: ascii = 8'h08;
          default: ascii = 8'h00;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - scan-code bytes to buffered key events with shift, repeat filter and press count
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       code_valid,
  input  logic [7:0] code,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic       ev_brk,
  output logic       ev_ext,
  output logic [7:0] ev_code,
  output logic [7:0] ev_ascii,
  output logic       shift,
  output logic [7:0] press_cnt,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  ps2_state_t state, next_state;
  logic       key_evt, key_brk, key_ext;
  logic [8:0] held_key;
  logic       held_valid;
  logic       shift_l, shift_r;
  logic       key_match, is_repeat, emit;
  logic [7:0] key_ascii;
  ps2_event_t new_ev, head;
  ps2_event_t mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic       empty, full, pop, push_ok;

  // Prefix state register; only moves when a byte arrives
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           state <= ST_IDLE;
    else if (code_valid) state <= next_state;
  end

  // Next prefix state from the incoming byte
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (code == PS2_EXT)      next_state = ST_EXT;
        else if (code == PS2_BRK) next_state = ST_BRK;
        else                      next_state = ST_IDLE;
      end
      ST_EXT: begin
        if (code == PS2_BRK)      next_state = ST_EXT_BRK;
        else if (code == PS2_EXT) next_state = ST_EXT;
        else                      next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Decode whether this byte completes a key and what kind it is
  always_comb begin
    key_evt = 1'b0;
    key_brk = 1'b0;
    key_ext = 1'b0;
    if (code_valid) begin
      case (state)
        ST_IDLE: key_evt = (code != PS2_EXT) && (code != PS2_BRK);
        ST_EXT: begin
          key_evt = (code != PS2_EXT) && (code != PS2_BRK);
          key_ext = 1'b1;
        end
        ST_BRK: begin
          key_evt = 1'b1;
          key_brk = 1'b1;
        end
        default: begin
          key_evt = 1'b1;
          key_brk = 1'b1;
          key_ext = 1'b1;
        end
      endcase
    end
  end

  assign key_match = held_valid && (held_key == {key_ext, code});
  assign is_repeat = key_evt && !key_brk && key_match;
  assign emit      = key_evt && !is_repeat;
  assign shift     = shift_l | shift_r;

  ps2_ascii_map u_ascii_map (
    .code  (code),
    .ext   (key_ext),
    .shift (shift),
    .ascii (key_ascii)
  );

  // Held key, shift flags and press counter track emitted events only
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_key   <= '0;
      held_valid <= 1'b0;
      shift_l    <= 1'b0;
      shift_r    <= 1'b0;
      press_cnt  <= 8'h00;
    end else if (emit) begin
      if (!key_brk) begin
        held_key   <= {key_ext, code};
        held_valid <= 1'b1;
        press_cnt  <= press_cnt + 8'd1;
      end else if (key_match) begin
        held_valid <= 1'b0;
      end
      if (!key_ext && code == PS2_LSHIFT) shift_l <= !key_brk;
      if (!key_ext && code == PS2_RSHIFT) shift_r <= !key_brk;
    end
  end

  assign new_ev  = '{brk: key_brk, ext: key_ext, code: code, ascii: key_ascii};
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = ev_valid && ev_ready;
  assign push_ok = emit && (!full || pop);

  // FIFO pointers and sticky overflow on a dropped event
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok)             wr_ptr   <= wr_ptr + (AW+1)'(1);
      if (pop)                 rd_ptr   <= rd_ptr + (AW+1)'(1);
      if (emit && full && !pop) overflow <= 1'b1;
    end
  end

  // FIFO storage; contents are never observed while empty so no reset is needed
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= new_ev;
  end

  assign head     = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign ev_valid = !empty;
  assign ev_brk   = head.brk;
  assign ev_ext   = head.ext;
  assign ev_code  = head.code;
  assign ev_ascii = head.ascii;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - scoreboard bench for ps2_key_decoder with a behavioural key model
module tb_ps2_key_decoder;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       code_valid;
  logic [7:0] code;
  logic       ev_valid;
  logic       ev_ready;
  logic       ev_brk;
  logic       ev_ext;
  logic [7:0] ev_code;
  logic [7:0] ev_ascii;
  logic       shift;
  logic [7:0] press_cnt;
  logic       overflow;

  ps2_key_decoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .code_valid (code_valid),
    .code       (code),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_brk     (ev_brk),
    .ev_ext     (ev_ext),
    .ev_code    (ev_code),
    .ev_ascii   (ev_ascii),
    .shift      (shift),
    .press_cnt  (press_cnt),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_popped = 0;

  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                    8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                    8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                    8'h35, 8'h1A};
  logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                   8'h3E, 8'h46};

  // Reference model state
  bit         m_ext, m_brk;
  bit         m_held_v;
  logic [8:0] m_held;
  bit         m_shl, m_shr;
  logic [7:0] m_cnt;
  int         m_occ;
  bit         m_ovf;
  logic [17:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_ascii(input logic [7:0] c, input bit ext, input bit sh);
    if (ext) return 8'h00;
    for (int i = 0; i < 26; i++)
      if (letter_codes[i] == c) return (sh ? 8'h41 : 8'h61) + 8'(i);
    for (int i = 0; i < 10; i++)
      if (digit_codes[i] == c) return 8'h30 + 8'(i);
    if (c == 8'h29) return 8'h20;
    if (c == 8'h5A) return 8'h0D;
    if (c == 8'h66) return 8'h08;
    return 8'h00;
  endfunction

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_held_v = 0; m_held = '0;
    m_shl = 0; m_shr = 0; m_cnt = 8'h00; m_occ = 0; m_ovf = 0;
    exp_q.delete();
  endtask

  // One clock edge of the reference: prefixes accumulate until a key byte completes them
  task automatic model_step(input bit cv, input logic [7:0] c, input bit rdy);
    bit pop, have_ev, is_brk, is_ext, sh;
    logic [7:0] asc;
    pop = (m_occ > 0) && rdy;
    have_ev = 0;
    is_brk = 0;
    is_ext = 0;
    if (cv) begin
      if (!m_brk && c == 8'hE0) m_ext = 1;
      else if (!m_brk && c == 8'hF0) m_brk = 1;
      else begin
        is_brk = m_brk;
        is_ext = m_ext;
        m_brk = 0;
        m_ext = 0;
        have_ev = 1;
        if (!is_brk && m_held_v && m_held == {is_ext, c}) have_ev = 0;
      end
    end
    if (have_ev) begin
      sh  = m_shl || m_shr;
      asc = m_ascii(c, is_ext, sh);
      if (!is_brk) begin
        m_held = {is_ext, c};
        m_held_v = 1;
        m_cnt = m_cnt + 8'd1;
      end else if (m_held_v && m_held == {is_ext, c}) begin
        m_held_v = 0;
      end
      if (!is_ext && c == 8'h12) m_shl = !is_brk;
      if (!is_ext && c == 8'h59) m_shr = !is_brk;
      if (m_occ < DEPTH || pop) begin
        exp_q.push_back({is_brk, is_ext, c, asc});
        m_occ++;
      end else begin
        m_ovf = 1;
      end
    end
    if (pop) m_occ--;
  endtask

  task automatic cycle(input bit cv, input logic [7:0] c, input bit rdy);
    code_valid = cv;
    code       = c;
    ev_ready   = rdy;
    @(posedge clk);
    model_step(cv, c, rdy);
    #2;
  endtask

  task automatic send(input logic [7:0] bytes [$], input bit rdy);
    foreach (bytes[i]) begin
      cycle(1'b1, bytes[i], rdy);
      cycle(1'b0, 8'h00, rdy);
    end
  endtask

  task automatic drain(input int n);
    repeat (n) cycle(1'b0, 8'h00, 1'b1);
  endtask

  task automatic do_reset();
    code_valid = 1'b0;
    code       = 8'h00;
    ev_ready   = 1'b0;
    reset      = 1'b1;
    model_reset();
    @(negedge clk);
    chk("reset_ev_valid", ev_valid, 0);
    chk("reset_ev_fields", {ev_brk, ev_ext, ev_code, ev_ascii}, 0);
    chk("reset_shift", shift, 0);
    chk("reset_press_cnt", press_cnt, 0);
    chk("reset_overflow", overflow, 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  // Monitor: compare the FIFO head against the scoreboard whenever it is consumed
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      chk("ev_valid", ev_valid, (exp_q.size() != 0));
      if (ev_valid && ev_ready && exp_q.size() != 0) begin
        chk("event", {ev_brk, ev_ext, ev_code, ev_ascii}, exp_q.pop_front());
        n_popped++;
      end
      chk("shift", shift, m_shl || m_shr);
      chk("press_cnt", press_cnt, m_cnt);
      chk("overflow", overflow, m_ovf);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    logic [7:0] b;
    logic [7:0] seq [$];
    reset = 1'b1;
    code_valid = 1'b0;
    code = 8'h00;
    ev_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #2;
    do_reset();

    // Make then break of 'a'
    p0 = n_popped;
    seq = '{8'h1C, 8'hF0, 8'h1C};
    send(seq, 1'b1);
    drain(4);
    chk("t1_events", n_popped - p0, 2);
    chk("t1_press_cnt", press_cnt, 1);

    // Shifted 'A'
    do_reset();
    seq = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12};
    send(seq, 1'b1);
    drain(4);
    chk("t2_shift_end", shift, 0);
    chk("t2_press_cnt", press_cnt, 2);

    // Extended key make/break
    do_reset();
    p0 = n_popped;
    seq = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'h1C};
    send(seq, 1'b1);
    drain(4);
    chk("t3_events", n_popped - p0, 3);

    // Typematic repeat suppression
    do_reset();
    p0 = n_popped;
    seq = '{8'h1C, 8'h1C, 8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};
    send(seq, 1'b1);
    drain(4);
    chk("t4_events", n_popped - p0, 2);
    chk("t4_press_cnt", press_cnt, 1);

    // FIFO overflow with a stalled consumer
    do_reset();
    p0 = n_popped;
    seq.delete();
    for (int i = 0; i < 9; i++) seq.push_back(letter_codes[i]);
    send(seq, 1'b0);
    @(negedge clk);
    chk("t5_overflow", overflow, 1);
    chk("t5_press_cnt", press_cnt, 9);
    @(posedge clk);
    #2;
    drain(12);
    chk("t5_drained", n_popped - p0, 8);
    chk("t5_overflow_sticky", overflow, 1);

    // Reset discards a pending break prefix
    do_reset();
    seq = '{8'h1C, 8'hF0};
    send(seq, 1'b1);
    do_reset();
    p0 = n_popped;
    seq = '{8'h1C};
    send(seq, 1'b1);
    drain(3);
    chk("t6_events", n_popped - p0, 1);
    chk("t6_press_cnt", press_cnt, 1);

    // Randomised traffic with a randomly stalling consumer
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      case ($urandom_range(0, 9))
        0: b = 8'hE0;
        1: b = 8'hF0;
        2: b = 8'h12;
        3: b = 8'h59;
        4, 5, 6: b = letter_codes[$urandom_range(0, 25)];
        7: b = digit_codes[$urandom_range(0, 9)];
        8: begin
          case ($urandom_range(0, 2))
            0: b = 8'h29;
            1: b = 8'h5A;
            default: b = 8'h66;
          endcase
        end
        default: b = 8'($urandom_range(0, 255));
      endcase
      cycle($urandom_range(0, 99) < 60, b, $urandom_range(0, 99) < 70);
    end
    drain(DEPTH + 4);
    chk("rand_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
